// File: rtl/vx_dispatch_split.sv
// vx_dispatch_split: dispatch stage for one issue slot. Routes each instruction
// to a per-unit FIFO by execution-unit type. When the unit datapath is narrower
// than the warp, it splits the instruction into lane packets and skips packets
// whose lane mask is empty. It also counts per-unit stall cycles and dropped
// instructions.
//
// Handshake semantics:
//   Input: an instruction is consumed only in the cycle in_ready is high. Upstream
//   keeps in_* stable while in_valid && !in_ready. in_ready is high in the cycle
//   the last packet is written, or immediately for an invalid unit type.
//   Output (per unit u): a packet moves when out_valid[u] && out_ready[u]. out_valid
//   does not depend on out_ready, and in_ready has no combinational path from out_ready.
module vx_dispatch_split #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 4,
  parameter int NUM_EX      = 4,
  parameter int HDRW        = 64,
  parameter int LANEW       = 96,
  parameter int BUF_DEPTH   = 2,
  parameter int PERF_W      = 16,
  localparam int NUM_PKTS   = NUM_THREADS / NUM_LANES,
  localparam int EX_BITS    = (NUM_EX > 1) ? $clog2(NUM_EX) : 1,
  localparam int PIDW       = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1,
  localparam int TIDW       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [EX_BITS-1:0]                   in_ex_type,
  input  logic [NUM_THREADS-1:0]               in_tmask,
  input  logic [HDRW-1:0]                      in_hdr,
  input  logic [NUM_THREADS*LANEW-1:0]         in_data,
  output logic [NUM_EX-1:0]                    out_valid,
  input  logic [NUM_EX-1:0]                    out_ready,
  output logic [NUM_EX*HDRW-1:0]               out_hdr,
  output logic [NUM_EX*NUM_LANES-1:0]          out_tmask,
  output logic [NUM_EX*NUM_LANES*LANEW-1:0]    out_data,
  output logic [NUM_EX*PIDW-1:0]               out_pid,
  output logic [NUM_EX-1:0]                    out_sop,
  output logic [NUM_EX-1:0]                    out_eop,
  output logic [NUM_EX*TIDW-1:0]               out_last_tid,
  output logic [NUM_EX*PERF_W-1:0]             perf_stalls,
  output logic [PERF_W-1:0]                    drop_cnt
);

  localparam int PKTW = NUM_LANES * LANEW;
  localparam int ENTW = HDRW + NUM_LANES + PKTW + PIDW + 2 + TIDW;
  localparam int PTRW = $clog2(BUF_DEPTH);
  localparam int CNTW = $clog2(BUF_DEPTH + 1);

  // Splitter state: next packet index to consider, and whether the next
  // emitted packet is the first of its instruction.
  logic [PIDW-1:0]      cur_pid;
  logic                 sop_pend;

  logic [NUM_PKTS-1:0]  pkt_nz;
  logic                 found;
  logic [PIDW-1:0]      sel_pid;
  logic                 sel_eop;
  logic [TIDW-1:0]      last_tid;
  logic [NUM_LANES-1:0] sel_mask;
  logic [PKTW-1:0]      sel_data;
  logic                 type_ok;
  logic                 sel_full;
  logic                 wr_en;
  logic [NUM_EX-1:0]    fifo_full;
  logic [NUM_EX-1:0]    unit_wr;
  logic [ENTW-1:0]      wr_entry;

  // Pick the lowest non-empty packet at or above cur_pid. An empty mask
  // falls back to packet 0. Also find the highest active thread.
  always_comb begin
    pkt_nz   = '0;
    found    = 1'b0;
    sel_pid  = '0;
    sel_eop  = 1'b1;
    last_tid = '0;
    for (int p = 0; p < NUM_PKTS; p++) begin
      pkt_nz[p] = |in_tmask[p*NUM_LANES +: NUM_LANES];
    end
    for (int p = 0; p < NUM_PKTS; p++) begin
      if (!found && pkt_nz[p] && (p >= int'(cur_pid))) begin
        sel_pid = PIDW'(p);
        found   = 1'b1;
      end
    end
    for (int p = 0; p < NUM_PKTS; p++) begin
      if (pkt_nz[p] && (p > int'(sel_pid))) sel_eop = 1'b0;
    end
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (in_tmask[t]) last_tid = TIDW'(t);
    end
  end

  assign sel_mask = in_tmask[int'(sel_pid)*NUM_LANES +: NUM_LANES];
  assign sel_data = in_data[int'(sel_pid)*PKTW +: PKTW];
  assign type_ok  = int'(in_ex_type) < NUM_EX;

  // Full flag of the targeted unit. An out-of-range type never reports full.
  always_comb begin
    sel_full = 1'b0;
    unit_wr  = '0;
    for (int u = 0; u < NUM_EX; u++) begin
      if (int'(in_ex_type) == u) begin
        sel_full   = fifo_full[u];
        unit_wr[u] = wr_en;
      end
    end
  end

  assign wr_en    = !reset && in_valid && type_ok && !sel_full;
  assign in_ready = !reset && in_valid && (!type_ok || (!sel_full && sel_eop));
  assign wr_entry = {in_hdr, sel_mask, sel_data, sel_pid, sop_pend, sel_eop, last_tid};

  // Advance the splitter on each write; rewind after the last packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_pid  <= '0;
      sop_pend <= 1'b1;
    end else if (wr_en) begin
      if (sel_eop) begin
        cur_pid  <= '0;
        sop_pend <= 1'b1;
      end else begin
        cur_pid  <= sel_pid + PIDW'(1);
        sop_pend <= 1'b0;
      end
    end
  end

  // Count instructions addressed to a non-existent unit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (in_valid && !type_ok) begin
      drop_cnt <= drop_cnt + PERF_W'(1);
    end
  end

  for (genvar u = 0; u < NUM_EX; u++) begin : g_unit
    logic [ENTW-1:0]   mem [BUF_DEPTH];
    logic [PTRW-1:0]   wr_ptr;
    logic [PTRW-1:0]   rd_ptr;
    logic [CNTW-1:0]   count;
    logic              rd_en;
    logic [PERF_W-1:0] stalls;

    assign rd_en        = (count != '0) && out_ready[u];
    assign fifo_full[u] = (count == CNTW'(BUF_DEPTH));
    assign out_valid[u] = (count != '0);
    assign {out_hdr[u*HDRW +: HDRW], out_tmask[u*NUM_LANES +: NUM_LANES],
            out_data[u*PKTW +: PKTW], out_pid[u*PIDW +: PIDW],
            out_sop[u], out_eop[u], out_last_tid[u*TIDW +: TIDW]} = mem[rd_ptr];
    assign perf_stalls[u*PERF_W +: PERF_W] = stalls;

    // In-order FIFO; a full FIFO refuses the write even if a read happens.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      end else begin
        if (unit_wr[u]) begin
          mem[wr_ptr] <= wr_entry;
          wr_ptr      <= wr_ptr + PTRW'(1);
        end
        if (rd_en) rd_ptr <= rd_ptr + PTRW'(1);
        case ({unit_wr[u], rd_en})
          2'b10:   count <= count + CNTW'(1);
          2'b01:   count <= count - CNTW'(1);
          default: count <= count;
        endcase
      end
    end

    // Count cycles where a valid instruction for this unit waits on a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stalls <= '0;
      end else if (in_valid && (int'(in_ex_type) == u) && fifo_full[u]) begin
        stalls <= stalls + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vx_dispatch_split.sv
// Bench for vx_dispatch_split: 8 threads, 4 lanes, 3 units (type 3 is invalid).
module tb_vx_dispatch_split;
  localparam int NT = 8, NL = 4, NEX = 3, HDRW = 16, LANEW = 8, DEPTH = 2, PW = 16;
  localparam int PIDW = 1, TIDW = 3, EXB = 2, PKTW = NL * LANEW;

  typedef struct packed {
    logic [1:0]      unit;
    logic [HDRW-1:0] hdr;
    logic [NL-1:0]   mask;
    logic [PKTW-1:0] data;
    logic [PIDW-1:0] pid;
    logic            sop;
    logic            eop;
    logic [TIDW-1:0] tid;
  } pkt_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [EXB-1:0]        in_ex_type;
  logic [NT-1:0]         in_tmask;
  logic [HDRW-1:0]       in_hdr;
  logic [NT*LANEW-1:0]   in_data;
  logic [NEX-1:0]        out_valid;
  logic [NEX-1:0]        out_ready;
  logic [NEX*HDRW-1:0]   out_hdr;
  logic [NEX*NL-1:0]     out_tmask;
  logic [NEX*PKTW-1:0]   out_data;
  logic [NEX*PIDW-1:0]   out_pid;
  logic [NEX-1:0]        out_sop;
  logic [NEX-1:0]        out_eop;
  logic [NEX*TIDW-1:0]   out_last_tid;
  logic [NEX*PW-1:0]     perf_stalls;
  logic [PW-1:0]         drop_cnt;

  logic                  rand_ready;
  logic [NEX-1:0]        rnd_ready;
  logic [NEX-1:0]        forced_ready;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  pkt_t exp_q[$];
  int   rem_q[$];
  bit   m_first;
  int   drop_exp;
  int   stall_exp[NEX];

  vx_dispatch_split #(
    .NUM_THREADS(NT), .NUM_LANES(NL), .NUM_EX(NEX), .HDRW(HDRW),
    .LANEW(LANEW), .BUF_DEPTH(DEPTH), .PERF_W(PW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ex_type(in_ex_type),
    .in_tmask(in_tmask), .in_hdr(in_hdr), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_hdr(out_hdr),
    .out_tmask(out_tmask), .out_data(out_data), .out_pid(out_pid),
    .out_sop(out_sop), .out_eop(out_eop), .out_last_tid(out_last_tid),
    .perf_stalls(perf_stalls), .drop_cnt(drop_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  assign out_ready = rand_ready ? rnd_ready : forced_ready;

  initial begin
    rnd_ready = '0;
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = NEX'($urandom_range(0, 7));
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_unit(int u);
    for (int i = 0; i < exp_q.size(); i++) if (int'(exp_q[i].unit) == u) return i;
    return -1;
  endfunction

  function automatic int occ(int u);
    int n = 0;
    for (int i = 0; i < exp_q.size(); i++) if (int'(exp_q[i].unit) == u) n++;
    return n;
  endfunction

  // One model step: compare outputs against model, then apply this edge's reads/writes.
  task automatic step();
    int   idx[NEX];
    int   tgt;
    int   tocc;
    int   p;
    bit   exp_rdy;
    pkt_t e;
    for (int u = 0; u < NEX; u++) begin
      idx[u] = find_unit(u);
      chk($sformatf("out_valid[%0d]", u), 64'(out_valid[u]), 64'(idx[u] >= 0));
      if (idx[u] >= 0) begin
        e = exp_q[idx[u]];
        chk($sformatf("out_hdr[%0d]", u), 64'(out_hdr[u*HDRW +: HDRW]), 64'(e.hdr));
        chk($sformatf("out_tmask[%0d]", u), 64'(out_tmask[u*NL +: NL]), 64'(e.mask));
        chk($sformatf("out_data[%0d]", u), 64'(out_data[u*PKTW +: PKTW]), 64'(e.data));
        chk($sformatf("out_pid[%0d]", u), 64'(out_pid[u*PIDW +: PIDW]), 64'(e.pid));
        chk($sformatf("out_sop[%0d]", u), 64'(out_sop[u]), 64'(e.sop));
        chk($sformatf("out_eop[%0d]", u), 64'(out_eop[u]), 64'(e.eop));
        chk($sformatf("out_last_tid[%0d]", u), 64'(out_last_tid[u*TIDW +: TIDW]), 64'(e.tid));
      end
      chk($sformatf("perf_stalls[%0d]", u), 64'(perf_stalls[u*PW +: PW]), 64'(stall_exp[u]));
    end
    chk("drop_cnt", 64'(drop_cnt), 64'(drop_exp));
    tgt  = int'(in_ex_type);
    tocc = (tgt < NEX) ? occ(tgt) : 0;
    for (int u = 0; u < NEX; u++) begin
      if (idx[u] >= 0 && out_ready[u]) exp_q.delete(find_unit(u));
    end
    exp_rdy = 1'b0;
    if (in_valid) begin
      if (tgt >= NEX) begin
        exp_rdy = 1'b1;
        drop_exp++;
      end else if (tocc == DEPTH) begin
        stall_exp[tgt]++;
      end else begin
        if (rem_q.size() == 0) begin
          for (int q = 0; q < NT / NL; q++) if (in_tmask[q*NL +: NL] != '0) rem_q.push_back(q);
          if (rem_q.size() == 0) rem_q.push_back(0);
          m_first = 1'b1;
        end
        p = rem_q.pop_front();
        e.unit = 2'(tgt);
        e.hdr  = in_hdr;
        e.mask = in_tmask[p*NL +: NL];
        e.data = in_data[p*PKTW +: PKTW];
        e.pid  = PIDW'(p);
        e.sop  = m_first;
        e.eop  = (rem_q.size() == 0);
        e.tid  = '0;
        for (int t = 0; t < NT; t++) if (in_tmask[t]) e.tid = TIDW'(t);
        exp_q.push_back(e);
        m_first = 1'b0;
        exp_rdy = e.eop;
      end
    end
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
  endtask

  // Scoreboard / compare process
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_hdr", 64'(out_hdr), 64'(0));
        chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        exp_q.delete();
        rem_q.delete();
        drop_exp = 0;
        for (int u = 0; u < NEX; u++) stall_exp[u] = 0;
      end else begin
        step();
      end
    end
  end

  // Driver tasks
  task automatic reset_dut();
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drive(input logic [1:0] t, input logic [7:0] m, input logic [15:0] h,
                       input logic [63:0] d);
    in_valid   = 1'b1;
    in_ex_type = t;
    in_tmask   = m;
    in_hdr     = h;
    in_data    = d;
  endtask

  task automatic send(input logic [1:0] t, input logic [7:0] m, input logic [15:0] h,
                      input logic [63:0] d);
    bit done = 1'b0;
    @(posedge clk);
    #1;
    drive(t, m, h, d);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] m;
    reset = 1'b1;
    in_valid = 1'b0;
    in_ex_type = '0;
    in_tmask = '0;
    in_hdr = '0;
    in_data = '0;
    rand_ready = 1'b0;
    forced_ready = '1;
    m_first = 1'b0;
    drop_exp = 0;
    for (int u = 0; u < NEX; u++) stall_exp[u] = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single packet from the upper half of the warp
    reset_dut();
    @(posedge clk); #1; drive(2'd1, 8'hF0, 16'h1111, 64'h8877665544332211);
    @(negedge clk); chk("t1_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("t1_out_valid", 64'(out_valid), 64'(3'b010));
    chk("t1_pid", 64'(out_pid[1]), 64'(1));
    chk("t1_mask", 64'(out_tmask[7:4]), 64'(4'hF));
    chk("t1_sop_eop", 64'({out_sop[1], out_eop[1]}), 64'(2'b11));
    chk("t1_last_tid", 64'(out_last_tid[5:3]), 64'(7));
    chk("t1_data", 64'(out_data[63:32]), 64'(32'h88776655));

    // Two packets: lanes 0 and 7
    @(posedge clk); #1; drive(2'd1, 8'h81, 16'h2222, 64'h0102030405060708);
    @(negedge clk); chk("t2_in_ready_c0", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("t2_in_ready_c1", 64'(in_ready), 64'(1));
    chk("t2_p0", 64'({out_valid[1], out_pid[1], out_tmask[7:4], out_sop[1], out_eop[1]}),
        64'({1'b1, 1'b0, 4'h1, 1'b1, 1'b0}));
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("t2_p1", 64'({out_valid[1], out_pid[1], out_tmask[7:4], out_sop[1], out_eop[1]}),
        64'({1'b1, 1'b1, 4'h8, 1'b0, 1'b1}));

    // Back-pressure on unit 2
    reset_dut();
    forced_ready = 3'b011;
    @(posedge clk); #1; drive(2'd2, 8'h0F, 16'hA001, 64'h1);
    @(negedge clk); chk("t3_rdy_a", 64'(in_ready), 64'(1));
    @(posedge clk); #1; drive(2'd2, 8'h0F, 16'hA002, 64'h2);
    @(negedge clk); chk("t3_rdy_b", 64'(in_ready), 64'(1));
    @(posedge clk); #1; drive(2'd2, 8'h0F, 16'hA003, 64'h3);
    @(negedge clk); chk("t3_rdy_c0", 64'(in_ready), 64'(0));
    @(negedge clk); chk("t3_rdy_c1", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("t3_stalls_2", 64'(perf_stalls[47:32]), 64'(2));
    chk("t3_head_a", 64'(out_hdr[47:32]), 64'(16'hA001));
    @(posedge clk); #1; forced_ready = 3'b111;
    @(negedge clk);
    chk("t3_rdy_full", 64'(in_ready), 64'(0));
    chk("t3_read_a", 64'(out_hdr[47:32]), 64'(16'hA001));
    @(negedge clk);
    chk("t3_rdy_after_read", 64'(in_ready), 64'(1));
    chk("t3_read_b", 64'(out_hdr[47:32]), 64'(16'hA002));
    chk("t3_stalls_4", 64'(perf_stalls[47:32]), 64'(4));
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("t3_read_c", 64'({out_valid[2], out_hdr[47:32]}), 64'({1'b1, 16'hA003}));
    @(negedge clk); chk("t3_empty", 64'(out_valid[2]), 64'(0));

    // Empty thread mask
    @(posedge clk); #1; drive(2'd0, 8'h00, 16'h4444, 64'hFFFF);
    @(negedge clk); chk("t4_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("t4_pkt", 64'({out_valid[0], out_pid[0], out_tmask[3:0], out_sop[0], out_eop[0], out_last_tid[2:0]}),
        64'({1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 3'd0}));

    // Invalid unit type
    reset_dut();
    @(posedge clk); #1; drive(2'd3, 8'hFF, 16'h5555, 64'h0);
    @(negedge clk); chk("t5_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("t5_no_valid", 64'(out_valid), 64'(0));
    chk("t5_drop_cnt", 64'(drop_cnt), 64'(1));

    // Reset in the middle of a split
    reset_dut();
    @(posedge clk); #1; drive(2'd0, 8'h81, 16'h6001, 64'h11);
    @(negedge clk); chk("t6_rdy_c0", 64'(in_ready), 64'(0));
    @(posedge clk); #1; reset = 1'b1; in_valid = 1'b0;
    @(negedge clk); chk("t6_rst_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; drive(2'd0, 8'h81, 16'h6002, 64'h22);
    @(negedge clk); chk("t6_rdy_r0", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("t6_fresh_p0", 64'({out_valid[0], out_pid[0], out_sop[0], out_eop[0], out_hdr[15:0]}),
        64'({1'b1, 1'b0, 1'b1, 1'b0, 16'h6002}));
    chk("t6_rdy_r1", 64'(in_ready), 64'(1));
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("t6_fresh_p1", 64'({out_pid[0], out_sop[0], out_eop[0]}), 64'({1'b1, 1'b0, 1'b1}));

    // Randomized traffic with random downstream back-pressure
    idle(2);
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      m = 8'($urandom);
      case ($urandom_range(0, 5))
        0: m[3:0] = 4'h0;
        1: m[7:4] = 4'h0;
        2: m = ($urandom_range(0, 2) == 0) ? 8'h00 : m;
        default: ;
      endcase
      send(($urandom_range(0, 9) == 9) ? 2'd3 : 2'($urandom_range(0, NEX - 1)), m,
           16'($urandom), {$urandom, $urandom});
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    rand_ready = 1'b0;
    forced_ready = '1;
    idle(10);
    @(negedge clk);
    chk("drain_model_empty", 64'(exp_q.size()), 64'(0));
    chk("drain_out_valid", 64'(out_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
